// File: rtl/subpel_pkg.sv
// Shared definitions for the sub-pel window path: default window geometry,
// loader state encoding and a counter-width helper.
package subpel_pkg;

    localparam int WIN   = 15;
    localparam int PIX_W = 8;
    localparam int ROW_W = WIN * PIX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } win_state_e;

    // Width of a row/column index for a window of side n (never below one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_row_store.sv
// Window storage: WIN rows of ROW_W bits, one pixel lane written per cycle,
// asynchronous full-row read. Contents are intentionally not reset.
module pixel_row_store
    import subpel_pkg::*;
#(
    parameter int WIN   = subpel_pkg::WIN,
    parameter int PIX_W = subpel_pkg::PIX_W,
    localparam int ROW_W = WIN * PIX_W,
    localparam int IDX_W = idx_width(WIN)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [WIN-1:0]   wr_lane_en,
    input  logic [PIX_W-1:0] wr_pix,
    input  logic [IDX_W-1:0] rd_row,
    output logic [ROW_W-1:0] rd_data
);

    logic [ROW_W-1:0] rows_r [WIN];

    // Lane write: column 0 occupies the most significant pixel lane of a row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int lane = 0; lane < WIN; lane++) begin
                if (wr_lane_en[lane]) begin
                    rows_r[wr_row][ROW_W-1-lane*PIX_W -: PIX_W] <= wr_pix;
                end
            end
        end
    end

    assign rd_data = rows_r[rd_row];

endmodule

// File: rtl/pixel_window_loader.sv
// Loads a WIN x WIN pixel window from a raster stream, holds it until released
// and serves rows with zero latency. Optional macro: PIXEL_ROW_CLAMP_EN.
module pixel_window_loader
    import subpel_pkg::*;
#(
    parameter int WIN   = subpel_pkg::WIN,
    parameter int PIX_W = subpel_pkg::PIX_W,
    localparam int ROW_W = WIN * PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       next_row,
    output logic [ROW_W-1:0] in_row,
    output logic             win_valid,
    input  logic             win_release,
    output logic [7:0]       fill_cnt
);

    localparam int               IDX_W    = idx_width(WIN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [7:0]       NPIX     = 8'(WIN * WIN);
    localparam logic [7:0]       WIN_8    = 8'(WIN);

    win_state_e       state_r;
    logic [IDX_W-1:0] col_r;
    logic [IDX_W-1:0] row_r;
    logic [7:0]       fill_cnt_r;
    logic             win_valid_r;
    logic             pix_ready_r;

    logic             accept_s;
    logic             last_pix_s;
    logic [WIN-1:0]   lane_en_s;
    logic [IDX_W-1:0] rd_row_s;
    logic             rd_hit_s;
    logic [ROW_W-1:0] rd_data_s;

    assign accept_s   = pix_valid && pix_ready_r && (state_r == FILL);
    assign last_pix_s = (fill_cnt_r == (NPIX - 8'd1));
    assign lane_en_s  = WIN'(1) << col_r;

    // Loader FSM with write pointer, fill counter and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            col_r       <= '0;
            row_r       <= '0;
            fill_cnt_r  <= 8'd0;
            win_valid_r <= 1'b0;
            pix_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r     <= FILL;
                    col_r       <= '0;
                    row_r       <= '0;
                    fill_cnt_r  <= 8'd0;
                    win_valid_r <= 1'b0;
                    pix_ready_r <= 1'b1;
                end
                FILL: begin
                    if (accept_s) begin
                        if (fill_cnt_r < NPIX) begin
                            fill_cnt_r <= fill_cnt_r + 8'd1;
                        end
                        if (last_pix_s) begin
                            state_r     <= HOLD;
                            col_r       <= '0;
                            row_r       <= '0;
                            win_valid_r <= 1'b1;
                            pix_ready_r <= 1'b0;
                        end else if (col_r == IDX_LAST) begin
                            col_r <= '0;
                            row_r <= row_r + IDX_ONE;
                        end else begin
                            col_r <= col_r + IDX_ONE;
                        end
                    end
                end
                HOLD: begin
                    // Release restarts the fill from the top-left pixel.
                    if (win_release) begin
                        state_r     <= FILL;
                        col_r       <= '0;
                        row_r       <= '0;
                        fill_cnt_r  <= 8'd0;
                        win_valid_r <= 1'b0;
                        pix_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_r       <= '0;
                    row_r       <= '0;
                    fill_cnt_r  <= 8'd0;
                    win_valid_r <= 1'b0;
                    pix_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Read row selection, including the policy for rows below the window.
    always_comb begin
        rd_row_s = '0;
        rd_hit_s = 1'b0;
        if (next_row < WIN_8) begin
            rd_row_s = next_row[IDX_W-1:0];
            rd_hit_s = 1'b1;
        end else begin
`ifdef PIXEL_ROW_CLAMP_EN
            rd_row_s = IDX_LAST;
            rd_hit_s = 1'b1;
`else
            rd_row_s = '0;
            rd_hit_s = 1'b0;
`endif
        end
    end

    pixel_row_store #(
        .WIN   (WIN),
        .PIX_W (PIX_W)
    ) u_store (
        .clk        (clk),
        .wr_en      (accept_s),
        .wr_row     (row_r),
        .wr_lane_en (lane_en_s),
        .wr_pix     (pix_in),
        .rd_row     (rd_row_s),
        .rd_data    (rd_data_s)
    );

    // Stale or partial contents never leave the block while no window is held.
    assign in_row    = (win_valid_r && rd_hit_s) ? rd_data_s : '0;
    assign win_valid = win_valid_r;
    assign pix_ready = pix_ready_r;
    assign fill_cnt  = fill_cnt_r;

endmodule

// File: tb/tb_pixel_window_loader.sv
// Self-checking bench for pixel_window_loader: pixel-indexed window model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pixel_window_loader;

    localparam int WIN   = 15;
    localparam int PIX_W = 8;
    localparam int ROW_W = WIN * PIX_W;
    localparam int NPIX  = WIN * WIN;

    logic             clk;
    logic             rst;
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       next_row;
    logic [ROW_W-1:0] in_row;
    logic             win_valid;
    logic             win_release;
    logic [7:0]       fill_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model: phase 0 idle, 1 filling, 2 holding; pixels stored by arrival index.
    int         m_phase;
    int         m_cnt;
    logic [7:0] m_pix [NPIX];

    pixel_window_loader dut (
        .clk         (clk),
        .rst         (rst),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .next_row    (next_row),
        .in_row      (in_row),
        .win_valid   (win_valid),
        .win_release (win_release),
        .fill_cnt    (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROW_W-1:0] model_row(input logic [7:0] nr);
        logic [ROW_W-1:0] v;
        int r;
        v = '0;
        if (m_phase != 2) return v;
        if (nr >= 8'(WIN)) begin
`ifdef PIXEL_ROW_CLAMP_EN
            r = WIN - 1;
`else
            return v;
`endif
        end else begin
            r = int'(nr);
        end
        for (int c = 0; c < WIN; c++) v[ROW_W-1-c*PIX_W -: PIX_W] = m_pix[r*WIN + c];
        return v;
    endfunction

    function automatic logic [7:0] grad_pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [ROW_W-1:0] grad_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < WIN; c++) v[ROW_W-1-c*PIX_W -: PIX_W] = grad_pix(r, c);
        return v;
    endfunction

    // Behavioural model update on every rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_phase)
                0: begin
                    m_phase <= 1;
                    m_cnt   <= 0;
                end
                1: begin
                    if (pix_valid) begin
                        m_pix[m_cnt] <= pix_in;
                        m_cnt        <= m_cnt + 1;
                        if (m_cnt == NPIX - 1) m_phase <= 2;
                    end
                end
                2: begin
                    if (win_release) begin
                        m_phase <= 1;
                        m_cnt   <= 0;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pix_ready", 128'(pix_ready), 128'(m_phase == 1));
            chk("win_valid", 128'(win_valid), 128'(m_phase == 2));
            chk("fill_cnt", 128'(fill_cnt), 128'(m_cnt));
            chk("in_row", 128'(in_row), 128'(model_row(next_row)));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input bit ones, input int npix, input bit toggle, output int edges);
        int k;
        k = 0;
        edges = 0;
        while (k < npix) begin
            pix_valid = !(toggle && (edges % 2 == 1));
            pix_in    = ones ? 8'hFF : grad_pix(k / WIN, k % WIN);
            tick();
            edges++;
            if (pix_valid) k++;
        end
        pix_valid = 1'b0;
        pix_in    = 8'h00;
    endtask

    task automatic reset_lits(input string tag);
        chk({tag, "_pix_ready"}, 128'(pix_ready), 128'(0));
        chk({tag, "_win_valid"}, 128'(win_valid), 128'(0));
        chk({tag, "_fill_cnt"}, 128'(fill_cnt), 128'(0));
        chk({tag, "_in_row"}, 128'(in_row), 128'(0));
    endtask

    task automatic release_pulse(input string tag);
        win_release = 1'b1;
        tick();
        win_release = 1'b0;
        chk({tag, "_rel_win_valid"}, 128'(win_valid), 128'(0));
        chk({tag, "_rel_pix_ready"}, 128'(pix_ready), 128'(1));
        chk({tag, "_rel_fill_cnt"}, 128'(fill_cnt), 128'(0));
    endtask

    task automatic sweep_grad(input string tag);
        for (int r = 0; r < WIN; r++) begin
            next_row = 8'(r);
            @(negedge clk);
            chk({tag, "_sweep_row"}, 128'(in_row), 128'(grad_row(r)));
            tick();
        end
    endtask

    initial begin
        int edges;
        logic [ROW_W-1:0] ones_row;
        ones_row    = '1;
        rst         = 1'b0;
        pix_in      = 8'h00;
        pix_valid   = 1'b0;
        next_row    = 8'd0;
        win_release = 1'b0;
        repeat (3) tick();
        reset_lits("reset");
        check_en = 1'b1;

        // Reset release, then one idle edge into FILL.
        rst = 1'b1;
        tick();
        chk("fill_entry_pix_ready", 128'(pix_ready), 128'(1));

        // Gradient fill with continuous valid.
        fill(1'b0, NPIX, 1'b0, edges);
        chk("s1_win_valid", 128'(win_valid), 128'(1));
        chk("s1_fill_cnt", 128'(fill_cnt), 128'(225));
        next_row = 8'd3;
        @(negedge clk);
        chk("s1_row3_col0", 128'(in_row[119:112]), 128'(8'h30));
        chk("s1_row3_col14", 128'(in_row[7:0]), 128'(8'h3E));
        next_row = 8'd15;
        @(negedge clk);
`ifdef PIXEL_ROW_CLAMP_EN
        chk("s1_row15_clamp_col0", 128'(in_row[119:112]), 128'(8'hE0));
        chk("s1_row15_clamp_col14", 128'(in_row[7:0]), 128'(8'hEE));
`else
        chk("s1_row15_zero", 128'(in_row), 128'(0));
`endif
        tick();
        next_row = 8'd200;
        @(negedge clk);
`ifdef PIXEL_ROW_CLAMP_EN
        chk("s1_row200_clamp", 128'(in_row), 128'(grad_row(14)));
`else
        chk("s1_row200_zero", 128'(in_row), 128'(0));
`endif
        tick();
        sweep_grad("s6");

        // Pixels offered while holding must be refused and leave contents alone.
        pix_valid = 1'b1;
        pix_in    = 8'hAA;
        repeat (5) begin
            tick();
            chk("s3_hold_pix_ready", 128'(pix_ready), 128'(0));
        end
        pix_valid = 1'b0;
        next_row  = 8'd3;
        @(negedge clk);
        chk("s3_row3_kept", 128'(in_row), 128'(grad_row(3)));
        tick();
        release_pulse("s3");

        // Gradient fill with valid toggling every cycle.
        fill(1'b0, NPIX, 1'b1, edges);
        chk("s2_edges", 128'(edges), 128'(449));
        chk("s2_win_valid", 128'(win_valid), 128'(1));
        sweep_grad("s2");
        release_pulse("s2");

        // Reset in the middle of a fill, then a full 0xFF fill.
        fill(1'b0, 100, 1'b0, edges);
        chk("s4_partial_cnt", 128'(fill_cnt), 128'(100));
        rst = 1'b0;
        tick();
        reset_lits("s4_reset");
        rst = 1'b1;
        tick();
        fill(1'b1, NPIX, 1'b0, edges);
        chk("s4_win_valid", 128'(win_valid), 128'(1));
        for (int r = 0; r < WIN; r++) begin
            next_row = 8'(r);
            @(negedge clk);
            chk("s4_row_ff", 128'(in_row), 128'(ones_row));
            tick();
        end
        next_row = 8'd15;
        @(negedge clk);
`ifdef PIXEL_ROW_CLAMP_EN
        chk("s4_row15_clamp", 128'(in_row), 128'(ones_row));
`else
        chk("s4_row15_zero", 128'(in_row), 128'(0));
`endif
        tick();
        // A release pulse outside HOLD is ignored by the model and DUT alike.
        release_pulse("s4");
        win_release = 1'b1;
        tick();
        win_release = 1'b0;
        chk("s4_release_in_fill", 128'(pix_ready), 128'(1));
        repeat (2) tick();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_window_loader.md
PIXEL_WINDOW_LOADER -- requirements
Module: pixel_window_loader

Interface
REQ-001 SHALL have parameter WIN, default 15, meaning window side length in integer pixels.
REQ-002 SHALL have parameter PIX_W, default 8, meaning bits per pixel; the row width ROW_W is WIN*PIX_W (120 by default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port pix_in, input, PIX_W bits: raster-order pixel stream, row 0 col 0 first.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-007 SHALL have port pix_ready, output, 1 bit: the loader accepts pix_in this cycle.
REQ-008 SHALL have port next_row, input, 8 bits: row index requested by the interpolator.
REQ-009 SHALL have port in_row, output, ROW_W bits: the requested row, with col 0 in bits [ROW_W-1 -: PIX_W] and col WIN-1 in bits [PIX_W-1:0].
REQ-010 SHALL have port win_valid, output, 1 bit: a complete window is held and stable.
REQ-011 SHALL have port win_release, input, 1 bit: one-cycle pulse from the consumer saying the window is used.
REQ-012 SHALL have port fill_cnt, output, 8 bits: number of pixels accepted in the current fill.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, FILL, HOLD.
REQ-014 SHALL move IDLE->FILL on the first cycle after reset is released.
REQ-015 SHALL make pix_ready=1 only in FILL; a pixel is accepted on a cycle with pix_valid && pix_ready.
REQ-016 SHALL track the write position with col and row counters; col wraps WIN-1->0 and increments row.
REQ-017 SHALL write each accepted pixel into row[row], column col, in the same cycle it is accepted.
REQ-018 SHALL move FILL->HOLD on acceptance of pixel WIN*WIN-1 (pixel 224).
REQ-019 SHALL raise win_valid the cycle after that acceptance and drop pix_ready in that same cycle.
REQ-020 SHALL keep all stored rows unchanged while in HOLD.
REQ-021 SHALL drive in_row = row[next_row] combinationally with zero latency while win_valid=1.
REQ-022 SHALL drive in_row=0 while win_valid=0.
REQ-023 SHALL, on win_release=1 in HOLD, go to FILL the next cycle with win_valid=0 and fill_cnt=0; win_release SHALL be ignored outside HOLD.
REQ-024 SHALL apply the out-of-range rule of the Configuration section when next_row >= WIN.
REQ-025 SHALL hold the write pointer unchanged on a cycle where pix_valid drops mid-fill, with no bubble penalty.
REQ-026 SHALL saturate fill_cnt at WIN*WIN and clear it on entering FILL.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, force state=IDLE, col=row=0, fill_cnt=0, win_valid=0 and pix_ready=0.
REQ-028 SHALL leave stored pixel contents unspecified after reset, while in_row still reads 0 because win_valid=0.
REQ-029 SHALL abort a fill when reset is asserted mid-fill; the partial window is never exposed.

Configuration
REQ-030 SHALL clamp next_row >= WIN to row WIN-1 (bottom-edge replication) when PIXEL_ROW_CLAMP_EN is defined.
REQ-031 SHALL drive in_row=0 for next_row >= WIN when PIXEL_ROW_CLAMP_EN is undefined.

Structure
REQ-032 SHALL take WIN, PIX_W, ROW_W and the state enum (IDLE/FILL/HOLD) from the shared package subpel_pkg.
REQ-033 SHALL hold the window in one sub-module, pixel_row_store: WIN rows of ROW_W with a byte-lane write enable and an asynchronous row read port.
REQ-034 SHALL keep the FSM and counters in pixel_window_loader itself.

Verification
REQ-035 SHALL cover: reset release, then 225 pixels of value (r*16+c) with pix_valid=1 -> win_valid rises the cycle after pixel 224; next_row=3 gives in_row[119:112]=0x30 and in_row[7:0]=0x3E.
REQ-036 SHALL cover: pix_valid toggled 1/0 every cycle during the fill -> win_valid after exactly 449 cycles, with contents identical to the previous scenario.
REQ-037 SHALL cover: in HOLD, pixels offered with pix_valid=1 -> pix_ready=0 and row contents unchanged; win_release pulse -> next cycle win_valid=0, pix_ready=1, fill_cnt=0.
REQ-038 SHALL cover: rst=0 after 100 pixels, then a full fill of 0xFF -> every row reads 0xFF..FF and no stale data appears.
REQ-039 SHALL cover: next_row=15 in HOLD -> in_row equals row 14 with PIXEL_ROW_CLAMP_EN defined, and 0 without it.
REQ-040 SHALL cover: next_row swept 0..14 on consecutive cycles -> in_row changes in the same cycle as next_row (zero latency).
